product_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that turns the signed 16-bit product of the sequential signed multiplier into a sign flag and a 5-digit packed BCD magnitude. It sits directly upstream of the digit-selection and button-scroll stage, and drives that stage's 20-bit `bcd` input. Conversion uses the shift-and-add-3 (double-dabble) method, one bit per clock. The registered result stays stable between conversions, so the downstream display logic can sample it at any time.

---
 rtl/multiplier_pkg.sv | 14 +
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/product_bcd_converter.sv | 90 +++++++++
 tb/tb_product_bcd_converter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared constants and state encoding for the multiplier product path.
// The BCD converter imports it.
package multiplier_pkg;

    localparam int PRODUCT_WIDTH = 16;
    localparam int BCD_DIGITS    = 5;
    localparam int CNT_W         = $clog2(PRODUCT_WIDTH);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// before the next left shift.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5)
            adjusted = digit + 4'd3;
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-and-add-3 converter from the signed product to a sign flag
// and packed BCD magnitude, one bit per clock, with a held output register.
module product_bcd_converter
    import multiplier_pkg::*;
#(
    parameter int WIDTH  = PRODUCT_WIDTH,
    parameter int DIGITS = BCD_DIGITS,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      product,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [WIDTH-1:0]      shift;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   scratch_next;
    logic                  pend_sign;
    logic                  neg;
    logic [WIDTH-1:0]      mag;

    // 16'h8000 negates to itself, which is already the correct unsigned magnitude.
    always_comb begin
        neg = (SIGNED != 0) && product[WIDTH-1];
        mag = product;
        if (neg)
            mag = ~product + 1'b1;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[4*i +: 4]),
            .adjusted (adjusted[4*i +: 4])
        );
    end

    always_comb begin
        scratch_next = {adjusted[4*DIGITS-2:0], shift[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            scratch   <= '0;
            pend_sign <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            bcd       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift     <= mag;
                        pend_sign <= neg;
                        scratch   <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch <= scratch_next;
                    shift   <= {shift[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        bcd   <= scratch_next;
                        sign  <= pend_sign;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench: signed and unsigned converter instances share stimulus;
// expected results come from a decimal-arithmetic model.
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] product = '0;
    logic        busy, done, sign;
    logic [19:0] bcd;
    logic        busy_u, done_u, sign_u;
    logic [19:0] bcd_u;

    typedef struct {
        logic [19:0] bcd_s;
        logic        sign_s;
        logic [19:0] bcd_u;
        int          due;
    } entry_t;

    entry_t      q[$];
    int          cyc = 0;
    int          next_ok = 0;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] mb = '0;
    logic        ms = 1'b0;
    logic [19:0] mu = '0;

    always #5 clk = ~clk;

    product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .start(start), .product(product),
        .busy(busy), .done(done), .sign(sign), .bcd(bcd)
    );

    product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .product(product),
        .busy(busy_u), .done(done_u), .sign(sign_u), .bcd(bcd_u)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] to_bcd(input int value);
        logic [19:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic entry_t model(input logic [15:0] p, input int due);
        entry_t e;
        int     sval;
        sval     = int'($signed(p));
        e.sign_s = (sval < 0);
        e.bcd_s  = to_bcd(sval < 0 ? -sval : sval);
        e.bcd_u  = to_bcd(int'(p));
        e.due    = due;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the acceptance decision is made for the next rising edge.
    task automatic drive(input logic s, input logic [15:0] p, input logic r);
        int e;
        @(negedge clk);
        start   = s;
        product = p;
        rst     = r;
        e       = cyc + 1;
        if (r)
            next_ok = e + 1;
        else if (s && e >= next_ok) begin
            q.push_back(model(p, e + 16));
            next_ok = e + 17;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic wait_ready();
        while (cyc + 1 < next_ok)
            drive(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic run1(input logic [15:0] p);
        wait_ready();
        drive(1'b1, p, 1'b0);
    endtask

    // Monitor: checks every cycle, popping the scoreboard when a result is due.
    always @(posedge clk) begin
        logic exp_done, exp_busy;
        #1;
        if (rst) begin
            q.delete();
            mb = '0;
            ms = 1'b0;
            mu = '0;
        end
        exp_done = (q.size() > 0) && (q[0].due == cyc);
        exp_busy = (q.size() > 0) && (cyc >= q[0].due - 16) && (cyc < q[0].due);
        chk("done", done, exp_done);
        chk("done_u", done_u, exp_done);
        chk("busy", busy, exp_busy);
        chk("busy_u", busy_u, exp_busy);
        if (exp_done) begin
            mb = q[0].bcd_s;
            ms = q[0].sign_s;
            mu = q[0].bcd_u;
            void'(q.pop_front());
        end
        chk("bcd", bcd, mb);
        chk("sign", sign, ms);
        chk("bcd_u", bcd_u, mu);
        chk("sign_u", sign_u, 1'b0);
    end

    initial begin
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 1'b1);
        idle(2);

        run1(16'd0);
        run1(16'd12345);
        run1(16'hFFFF);
        run1(16'h8000);
        run1(16'h7FFF);

        run1(16'd100);
        idle(4);
        drive(1'b1, 16'd999, 1'b0);
        wait_ready();
        drive(1'b1, 16'd999, 1'b0);

        run1(16'd4321);
        idle(7);
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b1, 16'd555, 1'b1);
        idle(20);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 80) == 0)
                drive(1'($urandom), 16'($urandom), 1'b1);
            else
                drive($urandom_range(0, 3) == 0, 16'($urandom), 1'b0);
        end
        idle(20);

        chk("drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
